// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// IDLE picks a winner and grants it; WRITE commits its data (or drops it on clr/withdrawal).
module dff_bank_arbiter #(
   parameter int                NUM_REQ   = 4,
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   parameter int                CNT_W     = 16,
   localparam int               IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] wdata,
   input  logic                     clr,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     ack,
   output logic [IDX_W-1:0]         owner,
   output logic                     busy,
   output logic [WIDTH-1:0]         q,
   output logic [CNT_W-1:0]         wr_count
);

   typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   win_q, win_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               ack_q, ack_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [WIDTH-1:0]   store_q, store_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               found;
   logic [IDX_W-1:0]   pick;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   win_next;

   // First requester at or after ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign win_next = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      gnt_d   = '0;
      ack_d   = 1'b0;
      owner_d = owner_q;
      store_d = store_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr) store_d = RESET_VAL;
            if (found) begin
               gnt_d   = NUM_REQ'(1) << pick;
               win_d   = pick;
               state_d = WRITE;
            end
         end
         WRITE: begin
            state_d = IDLE;
            // clr keeps ptr so the dropped winner gets the next turn again.
            if (clr) begin
               store_d = RESET_VAL;
            end else if (req[win_q]) begin
               store_d = wdata[win_q*WIDTH +: WIDTH];
               ack_d   = 1'b1;
               owner_d = win_q;
               cnt_d   = cnt_q + CNT_W'(1);
               ptr_d   = win_next;
            end else begin
               ptr_d   = win_next;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         gnt_q   <= '0;
         ack_q   <= 1'b0;
         owner_q <= '0;
         store_q <= RESET_VAL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         owner_q <= owner_d;
         store_q <= store_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt      = gnt_q;
   assign ack      = ack_q;
   assign owner    = owner_q;
   assign busy     = (state_q == WRITE);
   assign q        = store_q;
   assign wr_count = cnt_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter (4 requesters, 8-bit data, 4-bit counter to exercise wrap).
module tb_dff_bank_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 8;
   localparam int CNT_W   = 4;

   logic                     clk;
   logic                     rst;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] wdata;
   logic                     clr;
   logic [NUM_REQ-1:0]       gnt;
   logic                     ack;
   logic [1:0]               owner;
   logic                     busy;
   logic [WIDTH-1:0]         q;
   logic [CNT_W-1:0]         wr_count;

   int n_cmp;
   int n_err;
   int exp_cnt;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] exp_d;

   dff_bank_arbiter #(
      .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .RESET_VAL(8'h00), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .wdata(wdata), .clr(clr),
      .gnt(gnt), .ack(ack), .owner(owner), .busy(busy), .q(q), .wr_count(wr_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      exp_cnt = 0;
   endtask

   // One grant cycle then one commit cycle for requester k with data d.
   task automatic expect_commit(input int k, input logic [WIDTH-1:0] d, input string tag);
      tick();
      check_eq({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << k));
      check_eq({tag, "_ack_lo"}, 32'(ack), 32'd0);
      tick();
      exp_cnt = (exp_cnt + 1) % 16;
      check_eq({tag, "_ack"}, 32'(ack), 32'd1);
      check_eq({tag, "_owner"}, 32'(owner), 32'(k));
      check_eq({tag, "_q"}, 32'(q), 32'(d));
      check_eq({tag, "_cnt"}, 32'(wr_count), 32'(exp_cnt));
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      exp_cnt = 0;
      req = '0;
      wdata = '0;
      clr = 1'b0;
      rst = 1'b1;
      tick();
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_ack", 32'(ack), 32'd0);
      check_eq("rst_owner", 32'(owner), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_q", 32'(q), 32'd0);
      check_eq("rst_cnt", 32'(wr_count), 32'd0);
      tick();
      rst = 1'b0;

      // single writer
      wdata[8 +: 8] = 8'hA5;
      req = 4'b0010;
      tick();
      check_eq("single_gnt", 32'(gnt), 32'b0010);
      check_eq("single_busy", 32'(busy), 32'd1);
      check_eq("single_ack_lo", 32'(ack), 32'd0);
      req = 4'b0000;
      req[1] = 1'b1;
      tick();
      exp_cnt = 1;
      check_eq("single_q", 32'(q), 32'hA5);
      check_eq("single_ack", 32'(ack), 32'd1);
      check_eq("single_owner", 32'(owner), 32'd1);
      check_eq("single_cnt", 32'(wr_count), 32'(exp_cnt));
      check_eq("single_gnt_lo", 32'(gnt), 32'd0);
      req = 4'b0000;
      tick();
      check_eq("single_ack_once", 32'(ack), 32'd0);

      // asynchronous reset in the WRITE cycle
      wdata[16 +: 8] = 8'h77;
      req = 4'b0100;
      tick();
      check_eq("rmid_gnt", 32'(gnt), 32'b0100);
      #2 rst = 1'b1;
      #1;
      check_eq("rmid_gnt_clr", 32'(gnt), 32'd0);
      check_eq("rmid_busy", 32'(busy), 32'd0);
      check_eq("rmid_q", 32'(q), 32'd0);
      check_eq("rmid_owner", 32'(owner), 32'd0);
      check_eq("rmid_cnt", 32'(wr_count), 32'd0);
      tick();
      check_eq("rmid_no_ack", 32'(ack), 32'd0);
      rst = 1'b0;
      req = 4'b0000;
      exp_cnt = 0;
      tick();
      check_eq("rmid_idle_ack", 32'(ack), 32'd0);
      wdata[0 +: 8] = 8'h11;
      req = 4'b0001;
      expect_commit(0, 8'h11, "post_rst");
      req = 4'b0000;
      tick();

      // round robin from reset with all requesters held
      do_reset();
      wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int c = 0; c < 5; c++) exp_q.push_back(wdata[(c % 4)*8 +: 8]);
      req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         exp_d = exp_q.pop_front();
         expect_commit(c % 4, exp_d, "rr");
      end
      check_eq("rr_cnt5", 32'(wr_count), 32'd5);
      req = 4'b0000;
      tick();
      check_eq("rr_idle_gnt", 32'(gnt), 32'd0);
      check_eq("rr_idle_busy", 32'(busy), 32'd0);

      // withdrawal: ptr=1, requester 2 wins then drops
      req = 4'b0100;
      tick();
      check_eq("wd_gnt", 32'(gnt), 32'b0100);
      req = 4'b0000;
      tick();
      check_eq("wd_no_ack", 32'(ack), 32'd0);
      check_eq("wd_q_hold", 32'(q), 32'h11);
      check_eq("wd_cnt_hold", 32'(wr_count), 32'(exp_cnt));
      req = 4'b1010;
      expect_commit(3, 8'h44, "wd_r3");
      expect_commit(1, 8'h22, "wd_r1");
      req = 4'b0000;
      tick();

      // clr collides with a write: ptr=2, requester 0 wins twice
      wdata[0 +: 8] = 8'h3C;
      req = 4'b0001;
      tick();
      check_eq("clr_gnt", 32'(gnt), 32'b0001);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_eq("clr_no_ack", 32'(ack), 32'd0);
      check_eq("clr_q", 32'(q), 32'd0);
      check_eq("clr_cnt", 32'(wr_count), 32'(exp_cnt));
      expect_commit(0, 8'h3C, "clr_retry");
      req = 4'b0000;

      // clr while idle
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_eq("clr_idle_q", 32'(q), 32'd0);
      check_eq("clr_idle_gnt", 32'(gnt), 32'd0);

      // counter wrap: keep requester 2 writing past 2^CNT_W
      req = 4'b0100;
      for (int c = 0; c < 10; c++) begin
         wdata[16 +: 8] = 8'(8'h80 + c);
         expect_commit(2, 8'(8'h80 + c), "wrap");
      end
      check_eq("wrap_cnt", 32'(wr_count), 32'd2);
      req = 4'b0000;
      tick();
      check_eq("wrap_ack_lo", 32'(ack), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
